// File: rtl/ram_1r1w_arbiter_pkg.sv
// Shared types and sizing helpers for the two-requester ram_1r1w front end.
package ram_1r1w_arbiter_pkg;

  typedef logic [0:0] state_t;

  localparam state_t StClear = 1'b0;
  localparam state_t StRun   = 1'b1;

  function automatic int unsigned ram_depth(input int unsigned addr_width);
    return 1 << addr_width;
  endfunction

  // Packed request width: valid + we + addr + wdata.
  function automatic int unsigned req_width(input int unsigned bit_width,
                                            input int unsigned addr_width);
    return 2 + addr_width + bit_width;
  endfunction

endpackage

// File: rtl/ram_1r1w_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the loser of the last grant.
module ram_1r1w_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;  // 0 favours requester 0, 1 favours requester 1

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = ptr_q ? 2'b10 : 2'b01;
      else      gnt = req;
    end
    ptr_d = ptr_q;
    if (|gnt) ptr_d = gnt[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ram_1r1w_arbiter.sv
// Front end for a 1R1W RAM: zero-fill sweep after reset, then independent round-robin
// arbitration of the read and write ports between two requesters, gated by gwe.
module ram_1r1w_arbiter
  import ram_1r1w_arbiter_pkg::*;
#(
  parameter int unsigned bit_width      = 16,
  parameter int unsigned addr_width     = 3,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic                  req0_we,
  input  logic                  req1_we,
  input  logic [addr_width-1:0] req0_addr,
  input  logic [addr_width-1:0] req1_addr,
  input  logic [bit_width-1:0]  req0_wdata,
  input  logic [bit_width-1:0]  req1_wdata,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [bit_width-1:0]  rsp0_rdata,
  output logic [bit_width-1:0]  rsp1_rdata,
  output logic [addr_width-1:0] ram_rsel,
  input  logic [bit_width-1:0]  ram_rdata,
  output logic [addr_width-1:0] ram_wsel,
  output logic [bit_width-1:0]  ram_wdata,
  output logic                  ram_we,
  output logic                  init_done
);

  localparam int unsigned           RamDepth  = ram_depth(addr_width);
  localparam logic [addr_width-1:0] LastAddr  = addr_width'(RamDepth - 1);
  localparam state_t                ResetState = CLEAR_ON_RESET ? StClear : StRun;

  state_t                state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [bit_width-1:0]  rsp0_rdata_q, rsp0_rdata_d;
  logic [bit_width-1:0]  rsp1_rdata_q, rsp1_rdata_d;

  logic       clearing, arb_en;
  logic [1:0] rd_req, wr_req, rd_gnt, wr_gnt;

  assign clearing = (state_q == StClear) && !rst;
  // Reset is folded in so no ready can leak out while rst is held.
  assign arb_en   = gwe && !rst && (state_q == StRun);
  assign rd_req   = {req1_valid && !req1_we, req0_valid && !req0_we};
  assign wr_req   = {req1_valid && req1_we,  req0_valid && req0_we};

  ram_1r1w_arbiter_rr_arb2 u_rd_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  ram_1r1w_arbiter_rr_arb2 u_wr_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  always_comb begin
    req0_ready = rd_gnt[0] || wr_gnt[0];
    req1_ready = rd_gnt[1] || wr_gnt[1];

    ram_rsel = '0;
    if (rd_gnt[1])      ram_rsel = req1_addr;
    else if (rd_gnt[0]) ram_rsel = req0_addr;

    ram_we    = 1'b0;
    ram_wsel  = '0;
    ram_wdata = '0;
    if (clearing) begin
      ram_we   = gwe;
      ram_wsel = cnt_q;
    end else if (wr_gnt[1]) begin
      ram_we    = 1'b1;
      ram_wsel  = req1_addr;
      ram_wdata = req1_wdata;
    end else if (wr_gnt[0]) begin
      ram_we    = 1'b1;
      ram_wsel  = req0_addr;
      ram_wdata = req0_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear && gwe) begin
      if (cnt_q == LastAddr) state_d = StRun;
      else                   cnt_d   = cnt_q + 1'b1;
    end

    rsp_valid_d  = rsp_valid_q;
    rsp0_rdata_d = rsp0_rdata_q;
    rsp1_rdata_d = rsp1_rdata_q;
    if (gwe) rsp_valid_d = rd_gnt;
    if (rd_gnt[0]) rsp0_rdata_d = ram_rdata;
    if (rd_gnt[1]) rsp1_rdata_d = ram_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ResetState;
      cnt_q        <= '0;
      rsp_valid_q  <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  assign rsp0_valid = rsp_valid_q[0] && gwe;
  assign rsp1_valid = rsp_valid_q[1] && gwe;
  assign rsp0_rdata = rsp0_rdata_q;
  assign rsp1_rdata = rsp1_rdata_q;
  assign init_done  = (state_q == StRun);

endmodule
